// File: rtl/synt_ps2_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter.
// Holds the transaction FSM state encoding, the error codes reported
// with the done pulse, and the helper that builds the 10-bit frame
// shifted out to the device.
package synt_ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    START     = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_state_e;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_NOACK   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Odd parity over the command byte: set when the byte has an even number of ones.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  // Frame bits in transmit order: data LSB first, odd parity, stop (1).
  // The start bit is not stored; it is driven directly in START.
  function automatic logic [9:0] make_frame(input logic [7:0] data);
    return {1'b1, odd_parity(data), data};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one raw PS/2 line plus a falling-edge detector.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   line_i    - asynchronous line state
//   level_o   - synchronized line level
//   fall_o    - high for one cycle when the synchronized level goes 1 -> 0
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Idle PS/2 lines float high, so the flops reset to 1 to avoid a false fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign fall_o  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte using the
// request-to-send sequence (inhibit clock, pull data, release clock,
// shift bits on device clock falls, check ACK, wait for idle bus).
// Ports:
//   clk, rst              - system clock, synchronous active-high reset
//   tx_data, tx_start     - command byte and one-cycle request (ignored while busy)
//   ps2_clk_in/ps2_dat_in - raw line states
//   ps2_clk_oe/ps2_dat_oe - 1 pulls the line low, 0 releases it
//   busy                  - accept cycle through done pulse, inclusive
//   done, err             - end-of-transaction pulse and status (ok/no ACK/timeout)
module ps2_host_tx
  import synt_ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic [1:0] err
);

  localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  logic          clk_sync_s;
  logic          clk_fall_s;
  logic          dat_sync_s;
  logic          dat_fall_unused;

  ps2_state_e    state_q;
  logic [9:0]    frame_q;
  logic [3:0]    idx_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          ack_ok_q;
  logic          clk_oe_q;
  logic          dat_oe_q;
  logic          busy_q;
  logic          done_q;
  logic [1:0]    err_q;

  ps2_sync_edge u_clk_sync (
    .clk     (clk),
    .rst     (rst),
    .line_i  (ps2_clk_in),
    .level_o (clk_sync_s),
    .fall_o  (clk_fall_s)
  );

  ps2_sync_edge u_dat_sync (
    .clk     (clk),
    .rst     (rst),
    .line_i  (ps2_dat_in),
    .level_o (dat_sync_s),
    .fall_o  (dat_fall_unused)
  );

  assign cnt_d = cnt_q + CW'(1);

  // Transaction FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      frame_q  <= 10'd0;
      idx_q    <= 4'd0;
      cnt_q    <= '0;
      ack_ok_q <= 1'b0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= ERR_OK;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          clk_oe_q <= 1'b0;
          dat_oe_q <= 1'b0;
          // busy_q is still high in the done cycle, which drops a coincident tx_start.
          busy_q   <= 1'b0;
          if (tx_start && !busy_q) begin
            frame_q  <= make_frame(tx_data);
            busy_q   <= 1'b1;
            err_q    <= ERR_OK;
            ack_ok_q <= 1'b0;
            cnt_q    <= '0;
            clk_oe_q <= 1'b1;
            state_q  <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
            dat_oe_q <= 1'b1;
            state_q  <= START;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        START: begin
          // Releasing the clock with data held low is the request to send.
          clk_oe_q <= 1'b0;
          dat_oe_q <= 1'b1;
          idx_q    <= 4'd0;
          cnt_q    <= '0;
          state_q  <= SEND;
        end
        SEND, ACK, WAIT_IDLE: begin
          cnt_q <= cnt_d;
          if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            // Timeout wins over any event in the same cycle and over a pending no-ACK.
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            done_q   <= 1'b1;
            err_q    <= ERR_TIMEOUT;
            state_q  <= IDLE;
          end else if (state_q == SEND) begin
            if (clk_fall_s) begin
              dat_oe_q <= ~frame_q[idx_q];
              if (idx_q == 4'd9) begin
                state_q <= ACK;
              end else begin
                idx_q <= idx_q + 4'd1;
              end
            end
          end else if (state_q == ACK) begin
            dat_oe_q <= 1'b0;
            if (clk_fall_s) begin
              ack_ok_q <= ~dat_sync_s;
              state_q  <= WAIT_IDLE;
            end
          end else begin
            if (clk_sync_s && dat_sync_s) begin
              done_q  <= 1'b1;
              err_q   <= ack_ok_q ? ERR_OK : ERR_NOACK;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          clk_oe_q <= 1'b0;
          dat_oe_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TO  = 2000;
  localparam int M_NORMAL  = 0;
  localparam int M_NOACK   = 1;
  localparam int M_TIMEOUT = 2;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       busy;
  logic       done;
  logic [1:0] err;

  logic dev_clk_low;
  logic dev_dat_low;
  logic clk_line;
  logic dat_line;

  assign clk_line = ~(ps2_clk_oe | dev_clk_low);
  assign dat_line = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .ps2_clk_in (clk_line),
    .ps2_dat_in (dat_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  err;
    logic [10:0] bits;
    int          nsamp;
    int          lat;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  int          mode = M_NORMAL;
  logic [10:0] samp;
  int          nsamp;
  int          inh_len;
  int          rel_cyc;

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Observer: inhibit length and clock-release cycle of each transaction.
  initial begin
    int run;
    logic prev_oe;
    run = 0;
    prev_oe = 1'b0;
    inh_len = 0;
    rel_cyc = 0;
    forever begin
      @(negedge clk);
      if (busy && ps2_clk_oe && !ps2_dat_oe) begin
        run++;
      end else if (run != 0) begin
        inh_len = run;
        run = 0;
      end
      if (busy && prev_oe && !ps2_clk_oe) rel_cyc = cyc;
      prev_oe = ps2_clk_oe;
    end
  end

  // Device model: 40-cycle clock, samples on rises, ACKs before fall 11.
  initial begin
    int m;
    int guard;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    samp = '0;
    nsamp = 0;
    forever begin
      @(negedge clk);
      if (busy && clk_line && !dat_line) begin
        m = mode;
        samp = '0;
        nsamp = 0;
        wait_cyc(20);
        samp[0] = dat_line;
        nsamp = 1;
        for (int k = 1; k <= 10; k++) begin
          if (m == M_TIMEOUT && k == 5) break;
          wait_cyc(20);
          dev_clk_low = 1'b1;
          wait_cyc(20);
          dev_clk_low = 1'b0;
          samp[k] = dat_line;
          nsamp++;
        end
        if (m != M_TIMEOUT) begin
          wait_cyc(10);
          if (m == M_NORMAL) dev_dat_low = 1'b1;
          wait_cyc(10);
          dev_clk_low = 1'b1;
          wait_cyc(20);
          dev_clk_low = 1'b0;
          wait_cyc(5);
          dev_dat_low = 1'b0;
        end
        guard = 0;
        while (busy && guard < 5000) begin
          @(negedge clk);
          guard++;
        end
        if (busy) check("model_wait_idle", 1, 0);
      end
    end
  end

  // Monitor: pops the expected response whenever the DUT pulses done.
  initial begin
    exp_t e;
    logic [10:0] mask;
    forever begin
      @(negedge clk);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          mask = '0;
          for (int i = 0; i < e.nsamp; i++) mask[i] = 1'b1;
          check("err", int'(err), int'(e.err));
          check("inhibit_len", inh_len, INH);
          check("nsamp", nsamp, e.nsamp);
          check("bits", int'(samp & mask), int'(e.bits));
          check("clk_oe_at_done", int'(ps2_clk_oe), 0);
          check("dat_oe_at_done", int'(ps2_dat_oe), 0);
          check("busy_at_done", int'(busy), 1);
          if (e.lat != 0) check("timeout_latency", cyc - rel_cyc, e.lat);
          @(negedge clk);
          check("busy_after_done", int'(busy), 0);
          check("done_one_cycle", int'(done), 0);
        end
      end
    end
  end

  task automatic issue(input logic [7:0] d, input int m);
    mode = m;
    tx_data = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic push(input logic [1:0] e_err, input logic [10:0] b, input int n, input int lat);
    exp_t e;
    e.err = e_err;
    e.bits = b;
    e.nsamp = n;
    e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int maxc);
    int c;
    c = 0;
    while (!done && c < maxc) begin
      @(negedge clk);
      c++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1;
    tx_start = 1'b0;
    tx_data = 8'h00;
    wait_cyc(3);
    check("rst_clk_oe", int'(ps2_clk_oe), 0);
    check("rst_dat_oe", int'(ps2_dat_oe), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    rst = 1'b0;
    wait_cyc(5);

    // 0xED: start 0, data 1,0,1,1,0,1,1,1, parity 1, stop 1
    push(2'b00, 11'b11111011010, 11, 0);
    issue(8'hED, M_NORMAL);
    wait_done(3000);
    wait_cyc(50);

    // 0xF4 with a stray tx_start during SEND and another in the done cycle
    push(2'b00, 11'b10111101000, 11, 0);
    issue(8'hF4, M_NORMAL);
    wait_cyc(80);
    tx_data = 8'h00;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_done(3000);
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_cyc(3);
    check("start_in_done_ignored", int'(busy), 0);
    wait_cyc(50);

    // 0xF4 without ACK
    push(2'b01, 11'b10111101000, 11, 0);
    issue(8'hF4, M_NOACK);
    wait_done(3000);
    wait_cyc(50);

    // 0xF4 with the device stalling after fall 4: start + 4 data bits seen
    push(2'b10, 11'b00000001000, 5, TO);
    issue(8'hF4, M_TIMEOUT);
    wait_done(3000);
    wait_cyc(50);

    // Reset during SEND: lines released and busy cleared, no done
    issue(8'hED, M_NORMAL);
    wait_cyc(100);
    rst = 1'b1;
    @(negedge clk);
    check("abort_clk_oe", int'(ps2_clk_oe), 0);
    check("abort_dat_oe", int'(ps2_dat_oe), 0);
    check("abort_busy", int'(busy), 0);
    rst = 1'b0;
    wait_cyc(600);

    // 0xFF after the abort: parity 1
    push(2'b00, 11'b11111111110, 11, 0);
    issue(8'hFF, M_NORMAL);
    wait_done(3000);
    wait_cyc(50);

    check("pending_expectations", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It is the opposite direction of the existing Keyboard receiver.
- Sends one command byte to the keyboard, such as 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset), using the PS/2 host request-to-send protocol.
- Drives the open-drain PS2_CLK/PS2_DAT lines through pull-low enables. The top-level tristate pads the lines.
- Asserts busy for the whole transaction. The top uses busy to gate the Keyboard receiver so it ignores the host's own frame.

Parameters:
- INHIBIT_CYCLES, 5000, clk cycles PS2_CLK is held low before the request (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000, maximum clk cycles from clock release to device idle (15 ms at 50 MHz).

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  8  command byte, sampled when tx_start is accepted.
- tx_start  in  1  one-cycle request. Ignored while busy=1.
- ps2_clk_in  in  1  raw PS2_CLK line state (asynchronous).
- ps2_dat_in  in  1  raw PS2_DAT line state (asynchronous).
- ps2_clk_oe  out  1  1 = pull PS2_CLK low, 0 = release.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low, 0 = release.
- busy  out  1  high from the accept cycle until the done pulse, inclusive.
- done  out  1  one-cycle pulse at the end of a transaction.
- err  out  2  valid with done: 00 ok, 01 no ACK, 10 timeout. Holds its value until the next accept.

Behaviour:
- Reset: state IDLE, ps2_clk_oe=0, ps2_dat_oe=0, busy=0, done=0, err=00, all counters 0.
  - rst mid-transaction releases both lines on the next clk edge with no done pulse.
- Input sync: ps2_clk_in and ps2_dat_in each pass through a 2-FF synchronizer.
  - fall = synced clk was 1 last cycle and is 0 this cycle.
- Frame register (10 bits): bits 0..7 = tx_data, LSB first; bit 8 = odd parity (~^tx_data); bit 9 = stop (1).
- Driven data bit: ps2_dat_oe = ~frame[idx]. Bit 0 is driven low, bit 1 is released.
- IDLE: tx_start=1 latches the frame, sets busy=1, clears err, and enters INHIBIT on the next cycle.
- INHIBIT: ps2_clk_oe=1, ps2_dat_oe=0 for exactly INHIBIT_CYCLES cycles, then go to START.
- START (1 cycle): ps2_clk_oe=1, ps2_dat_oe=1 (start bit).
  - Next state SEND: idx=0, timeout counter cleared.
- SEND: ps2_clk_oe=0; ps2_dat_oe=1 until the first fall.
  - On fall k (k=1..10): idx=k-1 and drive frame[idx].
  - Fall 10 drives the stop bit, i.e. the data line is released; then go to ACK.
- ACK: both lines released. On the next fall, sample synced dat:
  - 0 → ack_ok.
  - 1 → err=01 (recorded, not yet reported).
  - Either way go to WAIT_IDLE.
- WAIT_IDLE: when synced clk=1 and dat=1 on the same cycle:
  - pulse done=1 and drop busy on the following cycle;
  - err = 00 if ACK was seen, else 01.
- Timeout: in SEND, ACK and WAIT_IDLE the counter increments each cycle. On reaching TIMEOUT_CYCLES:
  - release both lines;
  - done=1 with err=10, overriding a pending 01;
  - return to IDLE.
- Simultaneous events: tx_start in the same cycle as done is ignored; the caller must re-issue.
- fall edges are ignored in IDLE, INHIBIT and START.
- Width rules: the inhibit/timeout counter is sized by $clog2(max(INHIBIT_CYCLES, TIMEOUT_CYCLES)+1). idx is 4 bits and never exceeds 9.

Decomposition:
- Package synt_ps2_pkg holds:
  - state enum {IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE};
  - error constants ERR_OK=2'b00, ERR_NOACK=2'b01, ERR_TIMEOUT=2'b10.
- One sub-module, ps2_sync_edge: 2-FF synchronizer plus falling-edge detector. Instantiated once for clk and once for dat; the dat instance leaves its edge output unused.
- The top-level wrapper converts oe to tristate (oe ? 1'b0 : 1'bz). This is not part of this block.

Test Plan:
- Bench configuration: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000. The device model clocks at a 40-cycle period, samples data on rising edges, and drives ACK low before fall 11.
- Send 0xED → clk held low exactly 20 cycles; sampled bits start 0, then 1,0,1,1,0,1,1,1, parity 1, stop 1; ACK given → done pulse, err=00, busy low 1 cycle after done.
- Send 0xF4 → data bits 0,0,1,0,1,1,1,1, parity 0 → err=00.
- Same as 0xF4 but the model omits ACK (dat stays high at fall 11) → done with err=01.
- Model stops clocking after fall 4 → at cycle 2000 after START both oe=0, done with err=10, state IDLE.
- tx_start pulsed during SEND → no effect on frame or timing. rst asserted during SEND → oe=0 next cycle, busy=0, no done. A following 0xFF send completes with err=00.
